// File: rtl/sync_fifo_aggregator_if.sv
// Bundle of the write-side and packet-side handshake signals of sync_fifo_aggregator.
// The slave modport is the aggregator's view; the master modport is the producer/consumer view.
interface sync_fifo_aggregator_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int FETCH_WIDTH = 6
);
  logic                              wenq;
  logic [DATA_WIDTH-1:0]             wdata;
  logic                              wfull_n;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;
  logic                              change_fetch_width;
  logic [2:0]                        input_fetch_width;

  modport master (
    output wenq, wdata, receiver_full_n, change_fetch_width, input_fetch_width,
    input  wfull_n, receiver_data, receiver_enq
  );

  modport slave (
    input  wenq, wdata, receiver_full_n, change_fetch_width, input_fetch_width,
    output wfull_n, receiver_data, receiver_enq
  );
endinterface

// File: rtl/sync_fifo_aggregator.sv
// Dual-clock FIFO (wclk -> clk) feeding a packet builder of runtime-selectable width.
// Optional sticky overflow output in the wclk domain is enabled by SFA_OVERFLOW_FLAG_EN.
module sync_fifo_aggregator #(
  parameter int DATA_WIDTH    = 8,
  parameter int FETCH_WIDTH   = 6,
  parameter int ADDR_WIDTH    = 2,
  parameter int DEFAULT_FETCH = 2
) (
  input  logic wclk,
  input  logic wrst_n,
  input  logic clk,
  input  logic rst_n,
`ifdef SFA_OVERFLOW_FLAG_EN
  output logic overflow,
`endif
  sync_fifo_aggregator_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = $clog2(FETCH_WIDTH + 1);

  typedef logic [ADDR_WIDTH:0] ptr_t;
  typedef logic [CW-1:0]       cnt_t;

  function automatic ptr_t bin_to_gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray_to_bin(input ptr_t g);
    ptr_t b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic cnt_t clamp_width(input logic [2:0] req);
    if (req == 3'd0) return cnt_t'(1);
    if (int'(req) > FETCH_WIDTH) return cnt_t'(FETCH_WIDTH);
    return cnt_t'(req);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  ptr_t wbin_q, wgray_q;
  ptr_t rq1_gray_q, rq2_gray_q;
  ptr_t wbin_nxt;
  ptr_t fill_w;
  logic wfull;
  logic wr_en;

  assign wbin_nxt    = wbin_q + ptr_t'(1);
  // Occupancy against the synchronized read pointer only ever overestimates.
  assign fill_w      = wbin_q - gray_to_bin(rq2_gray_q);
  assign wfull       = (fill_w == ptr_t'(DEPTH));
  assign bus.wfull_n = ~wfull;
  assign wr_en       = wrst_n & bus.wenq & ~wfull;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      rq1_gray_q <= '0;
      rq2_gray_q <= '0;
    end else begin
      rq1_gray_q <= rgray_q;
      rq2_gray_q <= rq1_gray_q;
      if (wr_en) begin
        wbin_q  <= wbin_nxt;
        wgray_q <= bin_to_gray(wbin_nxt);
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (wr_en) begin
      mem[wbin_q[ADDR_WIDTH-1:0]] <= bus.wdata;
    end
  end

`ifdef SFA_OVERFLOW_FLAG_EN
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      overflow <= 1'b0;
    end else if (bus.wenq && wfull) begin
      overflow <= 1'b1;
    end
  end
`endif

  // ---------------- read / packet domain ----------------
  ptr_t rbin_q, rgray_q;
  ptr_t wq1_gray_q, wq2_gray_q;
  ptr_t rbin_nxt;
  logic rempty;

  logic [DATA_WIDTH-1:0] lane_q [FETCH_WIDTH];
  cnt_t                  count_q;
  cnt_t                  active_w_q;
  cnt_t                  pending_w_q;
  cnt_t                  pending_nxt;
  logic                  complete;
  logic                  deq;
  logic                  boundary;
  logic [DATA_WIDTH-1:0] rd_word;

  assign rbin_nxt = rbin_q + ptr_t'(1);
  assign rempty   = (rgray_q == wq2_gray_q);
  assign rd_word  = mem[rbin_q[ADDR_WIDTH-1:0]];

  // active width is never zero, so a full count can only mean a finished packet
  assign complete         = (count_q == active_w_q);
  assign bus.receiver_enq = complete & bus.receiver_full_n;
  assign deq              = ~rempty & (~complete | bus.receiver_enq);
  assign boundary         = (count_q == '0) | bus.receiver_enq;
  // A request arriving on the boundary edge itself still governs the next packet.
  assign pending_nxt      = bus.change_fetch_width ? clamp_width(bus.input_fetch_width)
                                                   : pending_w_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rbin_q      <= '0;
      rgray_q     <= '0;
      wq1_gray_q  <= '0;
      wq2_gray_q  <= '0;
      count_q     <= '0;
      active_w_q  <= cnt_t'(DEFAULT_FETCH);
      pending_w_q <= cnt_t'(DEFAULT_FETCH);
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      wq1_gray_q  <= wgray_q;
      wq2_gray_q  <= wq1_gray_q;
      pending_w_q <= pending_nxt;

      if (boundary) begin
        active_w_q <= pending_nxt;
      end

      if (deq) begin
        rbin_q  <= rbin_nxt;
        rgray_q <= bin_to_gray(rbin_nxt);
      end

      if (bus.receiver_enq) begin
        // Clearing every lane keeps lanes above a narrower next width at zero.
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          lane_q[i] <= '0;
        end
        if (deq) begin
          lane_q[0] <= rd_word;
          count_q   <= cnt_t'(1);
        end else begin
          count_q   <= '0;
        end
      end else if (deq) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          if (count_q == cnt_t'(i)) begin
            lane_q[i] <= rd_word;
          end
        end
        count_q <= count_q + cnt_t'(1);
      end
    end
  end

  always_comb begin
    bus.receiver_data = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (cnt_t'(i) < active_w_q) begin
        bus.receiver_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_aggregator.sv
// Self-checking bench: a word-queue model predicts each packet; literal packets pin the model.
module tb_sync_fifo_aggregator;
  localparam int DW = 8;
  localparam int FW = 6;
  localparam int AW = 2;
  localparam int DF = 2;
  localparam int PW = FW * DW;

  logic wclk = 1'b0;
  logic clk  = 1'b0;
  logic wrst_n;
  logic rst_n;
`ifdef SFA_OVERFLOW_FLAG_EN
  logic overflow;
`endif

  always #5 wclk = ~wclk;
  always #7 clk  = ~clk;

  sync_fifo_aggregator_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) bus ();

  sync_fifo_aggregator #(
    .DATA_WIDTH(DW), .FETCH_WIDTH(FW), .ADDR_WIDTH(AW), .DEFAULT_FETCH(DF)
  ) dut (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .clk(clk),
    .rst_n(rst_n),
`ifdef SFA_OVERFLOW_FLAG_EN
    .overflow(overflow),
`endif
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int bp_mode  = 0;
  int cur_w    = DF;
  int pend_w   = DF;
  logic [DW-1:0] exp_q [$];
  logic [PW-1:0] pkt_log [$];
  logic [PW-1:0] exp_pkt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int clamp_req(input int r);
    if (r == 0) return 1;
    if (r > FW) return FW;
    return r;
  endfunction

  // Packet compare: every transfer must carry the next cur_w words of the stream.
  always @(negedge clk) begin
    if (rst_n === 1'b0) begin
      check("enq_in_reset", bus.receiver_enq, 0);
    end else if (bus.receiver_enq === 1'b1) begin
      check("enq_gated_by_full_n", bus.receiver_full_n, 1);
      if (exp_q.size() < cur_w) begin
        checks++;
        failures++;
        $display("FAIL pkt_underflow: packet seen, model holds %0d words, needs %0d",
                 exp_q.size(), cur_w);
      end else begin
        exp_pkt = '0;
        for (int i = 0; i < cur_w; i++) begin
          exp_pkt[i*DW +: DW] = exp_q.pop_front();
        end
        check("packet", bus.receiver_data, exp_pkt);
        pkt_log.push_back(bus.receiver_data);
        cur_w = pend_w;
      end
    end
  end

  initial begin
    bus.receiver_full_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       bus.receiver_full_n = 1'b1;
        1:       bus.receiver_full_n = 1'b0;
        default: bus.receiver_full_n = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic write_word(input logic [DW-1:0] d);
    int t = 0;
    @(posedge wclk);
    #2;
    while (bus.wfull_n !== 1'b1 && t < 300) begin
      @(posedge wclk);
      #2;
      t++;
    end
    if (t >= 300) begin
      checks++;
      failures++;
      $display("FAIL write_timeout: wfull_n stuck at %b, required 1", bus.wfull_n);
    end else begin
      bus.wenq  = 1'b1;
      bus.wdata = d;
      exp_q.push_back(d);
      @(posedge wclk);
      #2;
      bus.wenq = 1'b0;
    end
  endtask

  task automatic set_width(input int w);
    @(posedge clk);
    #1;
    bus.change_fetch_width = 1'b1;
    bus.input_fetch_width  = 3'(w);
    @(posedge clk);
    #1;
    bus.change_fetch_width = 1'b0;
    pend_w = clamp_req(w);
    if (exp_q.size() == 0) cur_w = pend_w;
  endtask

  task automatic drain();
    int t = 0;
    bp_mode = 0;
    repeat (12) @(posedge clk);
    while (exp_q.size() >= cur_w && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d words undelivered, width %0d", exp_q.size(), cur_w);
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    wrst_n = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    cur_w  = DF;
    pend_w = DF;
    repeat (5) @(posedge clk);
    #1;
    check("rst_receiver_enq", bus.receiver_enq, 0);
    check("rst_wfull_n", bus.wfull_n, 1);
`ifdef SFA_OVERFLOW_FLAG_EN
    check("rst_overflow", overflow, 0);
`endif
    wrst_n = 1'b1;
    rst_n  = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int accepted;
    logic [DW-1:0] nextv;
    bus.wenq               = 1'b0;
    bus.wdata              = '0;
    bus.change_fetch_width = 1'b0;
    bus.input_fetch_width  = '0;
    wrst_n = 1'b0;
    rst_n  = 1'b0;
    do_reset();

    // Default width 2: 0..3 -> {0,1},{2,3}
    base = pkt_log.size();
    for (int i = 0; i < 4; i++) write_word(DW'(i));
    drain();
    check("w2_count", pkt_log.size() - base, 2);
    check("w2_pkt0", pkt_log[base],     48'h0000_0000_0100);
    check("w2_pkt1", pkt_log[base + 1], 48'h0000_0000_0302);

    // Width change with a partial packet held
    base = pkt_log.size();
    for (int i = 0; i < 3; i++) write_word(DW'(i));
    drain();
    set_width(4);
    for (int i = 3; i < 12; i++) write_word(DW'(i));
    drain();
    check("chg_count", pkt_log.size() - base, 4);
    check("chg_pkt1", pkt_log[base + 1], 48'h0000_0000_0302);
    check("chg_pkt2", pkt_log[base + 2], 48'h0000_0706_0504);
    check("chg_pkt3", pkt_log[base + 3], 48'h0000_0B0A_0908);

    // Back-pressure: 4 in lanes + 4 in FIFO, then full
    base = pkt_log.size();
    bp_mode = 1;
    repeat (3) @(posedge clk);
    accepted = 0;
    nextv = 8'h20;
    repeat (60) begin
      @(posedge wclk);
      #2;
      if (accepted < 10 && bus.wfull_n === 1'b1) begin
        bus.wenq  = 1'b1;
        bus.wdata = nextv;
        exp_q.push_back(nextv);
        nextv++;
        accepted++;
      end else begin
        bus.wenq = 1'b0;
      end
    end
    @(posedge wclk);
    #2;
    bus.wenq = 1'b0;
    check("held_accepted", accepted, 8);
    check("held_wfull_n", bus.wfull_n, 0);
    bus.wenq  = 1'b1;
    bus.wdata = 8'hEE;
    @(posedge wclk);
    #2;
    bus.wenq = 1'b0;
`ifdef SFA_OVERFLOW_FLAG_EN
    check("overflow_set", overflow, 1);
`endif
    bp_mode = 0;
    for (int i = 8'h28; i < 8'h2C; i++) write_word(DW'(i));
    drain();
    check("bp_count", pkt_log.size() - base, 3);
    check("bp_pkt0", pkt_log[base],     48'h0000_2322_2120);
    check("bp_pkt1", pkt_log[base + 1], 48'h0000_2726_2524);
    check("bp_pkt2", pkt_log[base + 2], 48'h0000_2B2A_2928);

    // Clamp 7 -> 6 with random gaps and random back-pressure
    set_width(7);
    base = pkt_log.size();
    bp_mode = 2;
    for (int i = 8'h30; i < 8'h3C; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge wclk);
      write_word(DW'(i));
    end
    drain();
    check("w6_pkt0", pkt_log[base],     48'h3534_3332_3130);
    check("w6_pkt1", pkt_log[base + 1], 48'h3B3A_3938_3736);

    // Clamp 0 -> 1
    set_width(0);
    base = pkt_log.size();
    bp_mode = 2;
    for (int i = 8'h40; i < 8'h45; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge wclk);
      write_word(DW'(i));
    end
    drain();
    check("w1_count", pkt_log.size() - base, 5);
    check("w1_pkt4", pkt_log[base + 4], 48'h0000_0000_0044);

    // Random widths, lengths, gaps and back-pressure
    for (int k = 0; k < 8; k++) begin
      int n;
      set_width($urandom_range(0, 7));
      if (($urandom_range(0, 3)) == 0) set_width($urandom_range(0, 7));
      n = $urandom_range(1, 16);
      bp_mode = 2;
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge wclk);
        write_word(DW'($urandom_range(0, 255)));
      end
      drain();
    end

    // Reset both domains mid-packet, then a fresh stream at the default width
    set_width(4);
    for (int i = 8'h60; i < 8'h63; i++) write_word(DW'(i));
    repeat (8) @(posedge clk);
    do_reset();
    base = pkt_log.size();
    for (int i = 8'h50; i < 8'h53; i++) write_word(DW'(i));
    drain();
    check("rst_fresh_count", pkt_log.size() - base, 1);
    check("rst_fresh_pkt", pkt_log[base], 48'h0000_0000_5150);
    check("rst_fresh_partial", exp_q.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_aggregator.md
SYNC_FIFO_AGGREGATOR -- requirements
Module: sync_fifo_aggregator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter FETCH_WIDTH, default 6, maximum words per output packet.
REQ-003 SHALL have parameter ADDR_WIDTH, default 2, giving FIFO depth 2**ADDR_WIDTH (4).
REQ-004 SHALL have parameter DEFAULT_FETCH, default 2, the packet width after reset.
REQ-005 SHALL have wclk input 1: write-domain clock. The write reset is wrst_n, synchronous, active-low, on clock wclk.
REQ-006 SHALL have wrst_n input 1: write-domain reset, synchronous to wclk, active-low.
REQ-007 SHALL have clk input 1: read/aggregator clock, asynchronous to wclk.
REQ-008 SHALL have rst_n input 1: read-domain reset, synchronous to clk, active-low.
REQ-009 SHALL have wenq input 1: write strobe.
REQ-010 SHALL have wdata input DATA_WIDTH: write word.
REQ-011 SHALL have wfull_n output 1: FIFO not full, in the wclk domain.
REQ-012 SHALL have receiver_data output FETCH_WIDTH*DATA_WIDTH: packed packet, word 0 in bits [DATA_WIDTH-1:0].
REQ-013 SHALL have receiver_full_n input 1: downstream can accept.
REQ-014 SHALL have receiver_enq output 1: packet transfer strobe.
REQ-015 SHALL have change_fetch_width input 1: load a new packet width.
REQ-016 SHALL have input_fetch_width input 3: requested packet width.

Function
REQ-017 SHALL implement an asynchronous FIFO with binary-plus-Gray pointers of ADDR_WIDTH+1 bits and a 2-flop synchronizer in each direction.
REQ-018 SHALL write wdata on a wclk edge when wenq=1 and wfull_n=1; wenq while full SHALL be ignored with no pointer change.
REQ-019 SHALL deassert wfull_n when 2**ADDR_WIDTH entries are held, as judged from the synchronized read pointer (pessimistic).
REQ-020 SHALL derive internal empty from the synchronized write pointer; the first written word SHALL become dequeueable no later than 3 clk edges after its write edge.
REQ-021 SHALL dequeue one word per clk edge while the FIFO is non-empty, words held < active width, and no completed packet is pending.
REQ-022 SHALL store the k-th dequeued word of a packet in lane k (k=0 first).
REQ-023 SHALL mark a packet complete in the cycle after its last word is stored, when words held = active width.
REQ-024 SHALL drive receiver_enq = complete & receiver_full_n, with receiver_data stable while complete.
REQ-025 SHALL clear the completed packet on the edge where receiver_enq=1; the next word MAY be dequeued on that same edge into lane 0.
REQ-026 SHALL drive lanes at index >= active width to zero.
REQ-027 SHALL latch input_fetch_width into a pending register when change_fetch_width=1, clamping 0 to 1 and values > FETCH_WIDTH to FETCH_WIDTH.
REQ-028 SHALL apply the pending width only at a packet boundary (words held = 0); partial packets SHALL complete at the old width and no word SHALL be dropped or duplicated.
REQ-029 SHALL let the last change win when change_fetch_width pulses several times before a boundary.
REQ-030 SHALL preserve FIFO order end to end; a word stream w, w+1, ... SHALL produce lane i = first word + i, with the first word of each packet advancing by the width.

Reset
REQ-031 wrst_n=0 SHALL clear the write pointer and its synchronizer, and set wfull_n=1.
REQ-032 rst_n=0 SHALL clear the read pointer, synchronizer, lanes and word count, set receiver_enq=0, and set active and pending width to DEFAULT_FETCH.
REQ-033 Resetting one domain mid-operation SHALL be legal only together with the other; data in flight is then discarded.

Configuration
REQ-034 With SFA_OVERFLOW_FLAG_EN defined, SHALL add output overflow (1 bit, wclk domain), set sticky on wenq while wfull_n=0 and cleared by wrst_n; without the macro the port and logic SHALL be absent.

Verification
REQ-035 Width 2: write 0,1,2,3 -> packets {0,1}, {2,3}, receiver_enq one clk each, upper lanes 0.
REQ-036 Change to width 4 after 3 words at width 2 -> {2,?} completes at width 2, then packets {4,5,6,7}, {8,9,10,11}.
REQ-037 Hold receiver_full_n=0 while writing 10 words at width 4 -> wfull_n drops after 4 FIFO words plus 4 buffered, no loss; release -> in-order packets.
REQ-038 Request width 7 -> width 6 used; request 0 -> width 1; random wenq gaps -> lane values contiguous.
REQ-039 Enqueue on a full FIFO -> data unchanged, and overflow=1 when SFA_OVERFLOW_FLAG_EN is defined.
REQ-040 Assert both resets mid-packet -> receiver_enq=0, wfull_n=1, width=DEFAULT_FETCH, a fresh stream restarts at lane 0.
